alu_iter: RTL and testbench
===========================

Name: alu_iter

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU. Adds signed/unsigned compares, shifts, and XOR/NOR.
- Adds an iterative multiply/divide unit behind a valid/ready handshake.
- Sits between the register-file read stage and write-back of the next multi-cycle CPU. The controller stalls on in_ready/out_valid.
- The zero flag is defined for every op, not only SUB.

Parameters:
- WIDTH, 32: operand/result width in bits; must be >= 4 and a power of two.
- SHW, $clog2(WIDTH): shift-amount width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  op/num1/num2 valid this cycle.
- in_ready  output  1  block can accept an operation.
- op  input  4  operation code (see Behaviour).
- num1  input  WIDTH  operand A.
- num2  input  WIDTH  operand B / shift amount.
- out_valid  output  1  ans/zero valid; held until out_ready.
- out_ready  input  1  consumer takes the result.
- ans  output  WIDTH  registered result.
- zero  output  1  ans == 0.
- busy  output  1  state != IDLE.

Behaviour:
- Op codes:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR.
  - 0100 NOT num1; 0101 NOR; 0110 SUB; 0111 SLT (signed).
  - 1000 SLTU; 1001 SLL; 1010 SRL; 1011 SRA.
  - 1100 MULLO; 1101 MULHU; 1110 DIVU; 1111 REMU.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT/SLTU return 1 or 0, zero-extended.
  - Shifts use num2[SHW-1:0] only; upper bits are ignored.
  - MULLO/MULHU return the low/high WIDTH bits of the unsigned 2*WIDTH product.
  - DIVU/REMU are unsigned. For num2 == 0: DIVU = all ones, REMU = num1. No trap.
- States:
  - IDLE: in_ready=1. in_valid accepts and latches op and operands.
    - Ops 0000-1011: result computed and registered, go to DONE.
    - Ops 1100-1111: go to CALC, cnt = 0.
  - CALC: one shift-add (mul) or restoring-subtract (div) step per cycle. After WIDTH steps (cnt == WIDTH-1), register the result and go to DONE.
  - DONE: out_valid=1. ans and zero are stable. On out_ready go to IDLE.
- Latency, counted from the accept edge:
  - ops 0000-1011: out_valid asserted on the next cycle.
  - ops 1100-1111: out_valid asserted WIDTH+1 cycles later.
  - Throughput: one op per (latency + 1) cycles minimum. in_ready is low in CALC and DONE, so there is no overlap.
- in_valid while in_ready=0 is ignored; no queueing.
- The operation code is latched. Changes to op/num1/num2 after acceptance have no effect.
- zero = (ans == 0), registered together with ans for every op.
- Reset (synchronous, any state including mid-CALC) gives, on the next edge:
  - state=IDLE, in_ready=1, out_valid=0, busy=0, ans=0, zero=1, cnt=0.
  - Any partial mul/div is discarded.
- out_ready while out_valid=0 has no effect.
- No X outputs: every op code is defined.

Optional Feature:
- Macro: ALU_OVERFLOW_EN.
- When defined:
  - An extra output port `ovf` (1 bit) is added, registered alongside ans.
  - ovf = signed overflow for ADD/SUB (operand signs equal/differ and result sign differs). It is 0 for all other ops.
  - Reset value 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg:
  - localparams for the 16 op codes.
  - state enum {IDLE, CALC, DONE}.
  - helper function is_multicycle(op).
- One natural sub-module: mdu_iter, the WIDTH-step shift-add multiplier / restoring divider.
  - Interface: start, op[1:0], a, b, done, result.
  - Owns the step counter, partial product and remainder registers.
- alu_iter keeps the FSM, the single-cycle datapath and the output registers.

Test Plan (WIDTH=32):
- ADD 5+7, out_ready=1 -> out_valid one cycle after accept; ans=12, zero=0. SUB 0x10-0x10 -> ans=0, zero=1.
- SRA 0x8000_0000 by 0x24 (uses 4) -> 0xF800_0000. SLT 0xFFFF_FFFF,1 -> 1. SLTU same operands -> 0.
- MULLO 0xFFFF_FFFF*3 -> 0xFFFF_FFFD; MULHU same -> 2. out_valid exactly 33 cycles after accept; in_ready=0 throughout.
- DIVU 100/7 -> 14; REMU 100/7 -> 2. DIVU 100/0 -> 0xFFFF_FFFF; REMU 100/0 -> 100.
- Backpressure: hold out_ready=0 for 5 cycles after ADD completes -> ans and zero stable, in_ready=0, new in_valid ignored. Raise out_ready -> in_ready=1 on the next cycle.
- rst asserted at step 10 of DIVU -> next cycle out_valid=0, in_ready=1, ans=0, zero=1. A following ADD 1+1 -> 2.
- With ALU_OVERFLOW_EN: ADD 0x7FFF_FFFF+1 -> ovf=1; ADD 1+1 -> ovf=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: op codes, FSM states and op-class helper.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_NOT   = 4'b0100;
    localparam logic [3:0] OP_NOR   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_SLL   = 4'b1001;
    localparam logic [3:0] OP_SRL   = 4'b1010;
    localparam logic [3:0] OP_SRA   = 4'b1011;
    localparam logic [3:0] OP_MULLO = 4'b1100;
    localparam logic [3:0] OP_MULHU = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1110;
    localparam logic [3:0] OP_REMU  = 4'b1111;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // The top quarter of the op space is handled by the iterative mul/div unit.
    function automatic logic is_multicycle(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/alu_iter_mdu.sv
// mdu_iter: WIDTH-step shift-add multiplier / restoring divider.
// hi/lo registers are shared: mul keeps {partial product, multiplier},
// div keeps {remainder, dividend->quotient}. op[0] selects hi (MULHU/REMU) or lo.
// done/result are combinational on the final step so the caller can register
// the post-step value on the same edge.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    logic             running;
    logic [SHW-1:0]   cnt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] d_q;      // multiplicand or divisor
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic [WIDTH:0]   sum, trial;

    // One mul or div step from the current hi/lo state.
    always_comb begin
        sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? d_q : {WIDTH{1'b0}})};
        trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, d_q};
        hi_n  = hi_q;
        lo_n  = lo_q;
        if (op_q[1]) begin
            // A clear borrow bit means the divisor fits: keep the difference, quotient bit 1.
            // Divisor 0 always fits, which yields all-ones quotient and remainder = dividend.
            if (!trial[WIDTH]) begin
                hi_n = trial[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_n = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                lo_n = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            {hi_n, lo_n} = {sum, lo_q[WIDTH-1:1]};
        end
    end

    assign done   = running && (cnt == SHW'(WIDTH - 1));
    assign result = op_q[0] ? hi_n : lo_n;

    // Load operands on start, then advance one step per cycle for WIDTH cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            op_q    <= '0;
            d_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            op_q    <= op;
            d_q     <= op[1] ? b : a;
            hi_q    <= '0;
            lo_q    <= op[1] ? a : b;
        end else if (running) begin
            hi_q <= hi_n;
            lo_q <= lo_n;
            cnt  <= cnt + 1'b1;
            if (done)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_iter.sv
// alu_iter: registered ALU with valid/ready handshake and iterative mul/div.
// Optional macro ALU_OVERFLOW_EN adds the registered signed-overflow output ovf.
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ans,
    output logic             zero,
    output logic             busy
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    state_t           state_q, state_d;
    logic             ld_alu, ld_mdu, mdu_start, mdu_done;
    logic [WIDTH-1:0] alu_r, mdu_res;
    logic [SHW-1:0]   sh;

    assign sh = num2[SHW-1:0];

    mdu_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .start  (mdu_start),
        .op     (op[1:0]),
        .a      (num1),
        .b      (num2),
        .done   (mdu_done),
        .result (mdu_res)
    );

    // Single-cycle datapath on the live inputs; registered only on accept.
    always_comb begin
        alu_r = '0;
        case (op)
            OP_AND:  alu_r = num1 & num2;
            OP_OR:   alu_r = num1 | num2;
            OP_ADD:  alu_r = num1 + num2;
            OP_XOR:  alu_r = num1 ^ num2;
            OP_NOT:  alu_r = ~num1;
            OP_NOR:  alu_r = ~(num1 | num2);
            OP_SUB:  alu_r = num1 - num2;
            OP_SLT:  alu_r = {{(WIDTH-1){1'b0}}, ($signed(num1) < $signed(num2))};
            OP_SLTU: alu_r = {{(WIDTH-1){1'b0}}, (num1 < num2)};
            OP_SLL:  alu_r = num1 << sh;
            OP_SRL:  alu_r = num1 >> sh;
            OP_SRA:  alu_r = $signed(num1) >>> sh;
            OP_MULLO, OP_MULHU, OP_DIVU, OP_REMU: alu_r = '0;
            default: alu_r = '0;
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    logic alu_ovf;

    // Signed overflow: the result sign disagrees with what the operand signs allow.
    always_comb begin
        alu_ovf = 1'b0;
        if (op == OP_ADD)
            alu_ovf = (num1[WIDTH-1] == num2[WIDTH-1]) && (alu_r[WIDTH-1] != num1[WIDTH-1]);
        else if (op == OP_SUB)
            alu_ovf = (num1[WIDTH-1] != num2[WIDTH-1]) && (alu_r[WIDTH-1] != num1[WIDTH-1]);
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake decode.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        ld_alu    = 1'b0;
        ld_mdu    = 1'b0;
        mdu_start = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    if (is_multicycle(op)) begin
                        mdu_start = 1'b1;
                        state_d   = CALC;
                    end else begin
                        ld_alu  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                if (mdu_done) begin
                    ld_mdu  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Result registers: ans and zero (and ovf) always update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            ans  <= '0;
            zero <= 1'b1;
`ifdef ALU_OVERFLOW_EN
            ovf  <= 1'b0;
`endif
        end else if (ld_alu) begin
            ans  <= alu_r;
            zero <= (alu_r == '0);
`ifdef ALU_OVERFLOW_EN
            ovf  <= alu_ovf;
`endif
        end else if (ld_mdu) begin
            ans  <= mdu_res;
            zero <= (mdu_res == '0);
`ifdef ALU_OVERFLOW_EN
            ovf  <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter (WIDTH=32); expected results go through a scoreboard queue.
// Build with ALU_OVERFLOW_EN defined to also exercise the ovf output.
module tb_alu_iter;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = '0;
    logic [W-1:0] num1 = '0, num2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] ans;
    logic         zero, busy;
`ifdef ALU_OVERFLOW_EN
    logic         ovf;
`endif

    alu_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .num1(num1), .num2(num2), .out_valid(out_valid),
        .out_ready(out_ready), .ans(ans), .zero(zero), .busy(busy)
`ifdef ALU_OVERFLOW_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] ans;
        logic         zero;
        int           lat;
    } exp_t;
    exp_t sb[$];

    // observed values from the latest completion
    logic [W-1:0] got_ans;
    logic         got_zero;
    int           got_lat;
    logic         stall_ok;
    logic         timed_out;

    // Present one op while in_ready is high, push its expectation, then scramble inputs.
    task automatic send(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e);
        exp_t x;
        x.ans  = e;
        x.zero = (e == '0);
        x.lat  = is_multicycle(o) ? W + 1 : 1;
        sb.push_back(x);
        op = o; num1 = a; num2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op   = 4'($urandom);
        num1 = $urandom;
        num2 = $urandom;
    endtask

    // Wait (bounded) for out_valid; latency = first edge at which out_valid is sampled high.
    task automatic wait_out(input int limit);
        int n = 0;
        stall_ok = 1'b1;
        while (!out_valid && n < limit) begin
            if (in_ready || !busy) stall_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        timed_out = !out_valid;
        got_lat   = n + 1;
        got_ans   = ans;
        got_zero  = zero;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset busy got %b exp 0", busy); end
        checks++; if (ans !== '0)         begin errors++; $display("FAIL reset ans got %h exp 0", ans); end
        checks++; if (zero !== 1'b1)      begin errors++; $display("FAIL reset zero got %b exp 1", zero); end
`ifdef ALU_OVERFLOW_EN
        checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL reset ovf got %b exp 0", ovf); end
`endif
    endtask

    // Single-cycle ops, back to back: next op is sent the cycle after release.
    task automatic test_alu();
        logic [3:0]   t_op [15] = '{OP_ADD, OP_SUB, OP_SRA, OP_SLT, OP_SLTU, OP_AND, OP_OR,
                                    OP_XOR, OP_NOT, OP_NOR, OP_SLL, OP_SRL, OP_ADD, OP_SUB, OP_SLTU};
        logic [W-1:0] t_a  [15] = '{32'd5, 32'h10, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                    32'hF0F0_1234, 32'hF000_0000, 32'hAAAA_5555, 32'h0000_FFFF,
                                    32'hF0F0_F0F0, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd1};
        logic [W-1:0] t_b  [15] = '{32'd7, 32'h10, 32'h24, 32'd1, 32'd1,
                                    32'h0FF0_FF00, 32'h0000_000F, 32'hFFFF_0000, 32'd123,
                                    32'h0F0F_0000, 32'h21, 32'd31, 32'd1, 32'd1, 32'hFFFF_FFFF};
        logic [W-1:0] t_e  [15] = '{32'd12, 32'd0, 32'hF800_0000, 32'd1, 32'd0,
                                    32'h00F0_1200, 32'hF000_000F, 32'h5555_5555, 32'hFFFF_0000,
                                    32'h0000_0F0F, 32'd2, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd1};
        exp_t e;
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL alu[%0d] in_ready got %b exp 1", i, in_ready); end
            send(t_op[i], t_a[i], t_b[i], t_e[i]);
            wait_out(5);
            e = sb.pop_front();
            checks++;
            if (timed_out) begin errors++; $display("FAIL alu[%0d] timeout no out_valid", i); end
            checks++;
            if (got_ans !== e.ans)   begin errors++; $display("FAIL alu[%0d] ans got %h exp %h", i, got_ans, e.ans); end
            checks++;
            if (got_zero !== e.zero) begin errors++; $display("FAIL alu[%0d] zero got %b exp %b", i, got_zero, e.zero); end
            checks++;
            if (got_lat != e.lat)    begin errors++; $display("FAIL alu[%0d] latency got %0d exp %0d", i, got_lat, e.lat); end
            release_out();
        end
    endtask

    // Iterative ops: fixed latency and stalled input side while computing.
    task automatic test_mdu();
        logic [3:0]   t_op [7] = '{OP_MULLO, OP_MULHU, OP_DIVU, OP_REMU, OP_DIVU, OP_REMU, OP_MULLO};
        logic [W-1:0] t_a  [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'd100, 32'd100, 32'd0};
        logic [W-1:0] t_b  [7] = '{32'd3, 32'd3, 32'd7, 32'd7, 32'd0, 32'd0, 32'h1234_5678};
        logic [W-1:0] t_e  [7] = '{32'hFFFF_FFFD, 32'd2, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd100, 32'd0};
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            send(t_op[i], t_a[i], t_b[i], t_e[i]);
            wait_out(60);
            e = sb.pop_front();
            checks++;
            if (timed_out) begin errors++; $display("FAIL mdu[%0d] timeout no out_valid", i); end
            checks++;
            if (got_ans !== e.ans)   begin errors++; $display("FAIL mdu[%0d] ans got %h exp %h", i, got_ans, e.ans); end
            checks++;
            if (got_zero !== e.zero) begin errors++; $display("FAIL mdu[%0d] zero got %b exp %b", i, got_zero, e.zero); end
            checks++;
            if (got_lat != e.lat)    begin errors++; $display("FAIL mdu[%0d] latency got %0d exp %0d", i, got_lat, e.lat); end
            checks++;
            if (!stall_ok) begin errors++; $display("FAIL mdu[%0d] in_ready/busy during calc got stall_ok=0 exp 1", i); end
            release_out();
        end
    endtask

    // Random mix with expectations from plain arithmetic operators.
    task automatic test_random();
        logic [3:0]   pool [8] = '{OP_ADD, OP_SUB, OP_XOR, OP_SRA, OP_MULLO, OP_MULHU, OP_DIVU, OP_REMU};
        logic [3:0]   o;
        logic [W-1:0] a, b, ex;
        logic [2*W-1:0] p;
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            o = pool[$urandom_range(0, 7)];
            a = $urandom;
            b = (o == OP_DIVU || o == OP_REMU) ? W'($urandom_range(0, 50)) : $urandom;
            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            case (o)
                OP_ADD:   ex = a + b;
                OP_SUB:   ex = a - b;
                OP_XOR:   ex = a ^ b;
                OP_SRA:   ex = $signed(a) >>> b[4:0];
                OP_MULLO: ex = p[W-1:0];
                OP_MULHU: ex = p[2*W-1:W];
                OP_DIVU:  ex = (b == '0) ? {W{1'b1}} : a / b;
                OP_REMU:  ex = (b == '0) ? a : a % b;
                default:  ex = '0;
            endcase
            send(o, a, b, ex);
            wait_out(60);
            e = sb.pop_front();
            checks++;
            if (timed_out || got_ans !== e.ans) begin
                errors++;
                $display("FAIL rnd[%0d] op %h a %h b %h ans got %h exp %h", i, o, a, b, got_ans, e.ans);
            end
            checks++;
            if (got_lat != e.lat) begin errors++; $display("FAIL rnd[%0d] latency got %0d exp %0d", i, got_lat, e.lat); end
            release_out();
        end
    endtask

    // Hold out_ready low: result stable, new inputs ignored, then release.
    task automatic test_backpressure();
        exp_t e;
        send(OP_ADD, 32'd3, 32'd4, 32'd7);
        wait_out(5);
        e = sb.pop_front();
        checks++;
        if (timed_out || got_ans !== e.ans) begin errors++; $display("FAIL bp ans got %h exp %h", got_ans, e.ans); end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; op = OP_ADD; num1 = 32'd100; num2 = 32'd100;
            @(posedge clk); #1;
            checks++; if (ans !== e.ans)      begin errors++; $display("FAIL bp[%0d] ans got %h exp %h", i, ans, e.ans); end
            checks++; if (zero !== 1'b0)      begin errors++; $display("FAIL bp[%0d] zero got %b exp 0", i, zero); end
            checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp[%0d] in_ready got %b exp 0", i, in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp[%0d] out_valid got %b exp 1", i, out_valid); end
        end
        in_valid = 1'b0;
        release_out();
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp release in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp release out_valid got %b exp 0", out_valid); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp ignored-op out_valid got %b exp 0", out_valid); end
    endtask

    // Reset in the middle of a division discards it; the block is usable right after.
    task automatic test_reset_mid();
        exp_t e;
        logic seen;
        op = OP_DIVU; num1 = 32'd100; num2 = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rstmid in_ready got %b exp 1", in_ready); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rstmid busy got %b exp 0", busy); end
        checks++; if (ans !== '0)         begin errors++; $display("FAIL rstmid ans got %h exp 0", ans); end
        checks++; if (zero !== 1'b1)      begin errors++; $display("FAIL rstmid zero got %b exp 1", zero); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid stale result got out_valid=1 exp 0"); end
        send(OP_ADD, 32'd1, 32'd1, 32'd2);
        wait_out(5);
        e = sb.pop_front();
        checks++;
        if (timed_out || got_ans !== e.ans) begin errors++; $display("FAIL rstmid add ans got %h exp %h", got_ans, e.ans); end
        release_out();
    endtask

`ifdef ALU_OVERFLOW_EN
    task automatic test_ovf();
        logic [3:0]   t_op [4] = '{OP_ADD, OP_ADD, OP_SUB, OP_XOR};
        logic [W-1:0] t_a  [4] = '{32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [W-1:0] t_b  [4] = '{32'd1, 32'd1, 32'd1, 32'd1};
        logic [W-1:0] t_e  [4] = '{32'h8000_0000, 32'd2, 32'h7FFF_FFFF, 32'h7FFF_FFFE};
        logic         t_v  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            send(t_op[i], t_a[i], t_b[i], t_e[i]);
            wait_out(5);
            e = sb.pop_front();
            checks++;
            if (timed_out || got_ans !== e.ans) begin errors++; $display("FAIL ovf[%0d] ans got %h exp %h", i, got_ans, e.ans); end
            checks++;
            if (ovf !== t_v[i]) begin errors++; $display("FAIL ovf[%0d] ovf got %b exp %b", i, ovf, t_v[i]); end
            release_out();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_mdu();
        test_random();
        test_backpressure();
        test_reset_mid();
`ifdef ALU_OVERFLOW_EN
        test_ovf();
`endif
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard leftover got %0d exp 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
